// File: rtl/ids_dma_mc.sv
// Multi-channel word-copy DMA sharing one bus master; round-robin, 4 cycles/word min.
// Grant low stalls RD/WR with strobes held off; start/abort are per-channel pulses.
module ids_dma_mc #(
  parameter int XLEN   = 32,
  parameter int NUM_CH = 2,
  parameter int LEN_W  = 13
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_CH-1:0]       i_ch_start,
  input  logic [NUM_CH-1:0]       i_ch_abort,
  input  logic [NUM_CH*XLEN-1:0]  i_ch_src,
  input  logic [NUM_CH*XLEN-1:0]  i_ch_dst,
  input  logic [NUM_CH*LEN_W-1:0] i_ch_len,
  output logic [NUM_CH-1:0]       o_ch_busy,
  output logic [NUM_CH-1:0]       o_ch_done,
  output logic                    o_bus_req,
  input  logic                    i_bus_gnt,
  output logic [XLEN-1:0]         o_bus_addr,
  output logic                    o_bus_read,
  output logic                    o_bus_write,
  output logic [3:0]              o_bus_size,
  output logic [XLEN-1:0]         o_bus_wr_data,
  input  logic [XLEN-1:0]         i_bus_rd_data
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  state_t            state, state_nxt;
  logic [XLEN-1:0]   src [NUM_CH];
  logic [XLEN-1:0]   dst [NUM_CH];
  logic [LEN_W-1:0]  remaining [NUM_CH];
  logic [NUM_CH-1:0] busy, done;
  logic [CH_W-1:0]   last, winner, pick, rr_ch;
  logic [CH_W:0]     rr_sum;
  logic              pick_vld;
  logic [XLEN-1:0]   data_q;
  logic              abort_pend;
  logic              wr_done;

  // Scan downwards so the nearest busy channel after 'last' is the one left in pick.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    rr_sum   = '0;
    rr_ch    = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      rr_sum = {1'b0, last} + (CH_W+1)'(i);
      if (rr_sum >= (CH_W+1)'(NUM_CH)) rr_sum = rr_sum - (CH_W+1)'(NUM_CH);
      rr_ch = CH_W'(rr_sum);
      if (busy[rr_ch] && !i_ch_abort[rr_ch]) begin
        pick     = rr_ch;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    o_bus_req     = 1'b0;
    o_bus_addr    = '0;
    o_bus_read    = 1'b0;
    o_bus_write   = 1'b0;
    o_bus_size    = 4'h0;
    o_bus_wr_data = '0;
    wr_done       = 1'b0;
    case (state)
      IDLE: begin
        o_bus_req = |busy;
        if (pick_vld) state_nxt = RD;
      end
      RD: begin
        o_bus_req  = 1'b1;
        o_bus_addr = src[winner];
        o_bus_read = i_bus_gnt;
        if (i_bus_gnt) state_nxt = CAP;
      end
      CAP: begin
        o_bus_req = 1'b1;
        state_nxt = WR;
      end
      WR: begin
        o_bus_req     = 1'b1;
        o_bus_addr    = dst[winner];
        o_bus_wr_data = data_q;
        o_bus_size    = 4'hF;
        o_bus_write   = i_bus_gnt;
        if (i_bus_gnt) begin
          state_nxt = IDLE;
          wr_done   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      last       <= CH_W'(NUM_CH-1);
      winner     <= '0;
      data_q     <= '0;
      abort_pend <= 1'b0;
      busy       <= '0;
      done       <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        src[k]       <= '0;
        dst[k]       <= '0;
        remaining[k] <= '0;
      end
    end else begin
      state <= state_nxt;
      done  <= '0;
      if (state == IDLE && pick_vld) begin
        winner     <= pick;
        abort_pend <= 1'b0;
      end else if (state != IDLE && i_ch_abort[winner]) begin
        abort_pend <= 1'b1;
      end
      if (state == CAP) data_q <= i_bus_rd_data;
      if (wr_done) last <= winner;
      for (int k = 0; k < NUM_CH; k++) begin
        if (!busy[k]) begin
          if (i_ch_start[k] && !i_ch_abort[k]) begin
            src[k]       <= i_ch_src[k*XLEN +: XLEN];
            dst[k]       <= i_ch_dst[k*XLEN +: XLEN];
            remaining[k] <= i_ch_len[k*LEN_W +: LEN_W];
            if (i_ch_len[k*LEN_W +: LEN_W] != '0) busy[k] <= 1'b1;
            else                                  done[k] <= 1'b1;
          end
        end else if (state != IDLE && CH_W'(k) == winner) begin
          // The winner's abort is deferred until its in-flight word is written.
          if (wr_done) begin
            src[k]       <= src[k] + XLEN'(4);
            dst[k]       <= dst[k] + XLEN'(4);
            remaining[k] <= remaining[k] - LEN_W'(1);
            if (abort_pend || i_ch_abort[k]) begin
              busy[k] <= 1'b0;
            end else if (remaining[k] == LEN_W'(1)) begin
              busy[k] <= 1'b0;
              done[k] <= 1'b1;
            end
          end
        end else if (i_ch_abort[k]) begin
          busy[k] <= 1'b0;
        end
      end
    end
  end

  assign o_ch_busy = busy;
  assign o_ch_done = done;

endmodule

// File: tb/tb_ids_dma_mc.sv
// Bench for ids_dma_mc: directed scenarios plus randomized jobs checked against a
// round-robin word-list model and a pattern-returning synchronous SRAM.
module tb_ids_dma_mc;
  localparam int XLEN  = 32;
  localparam int NCH   = 2;
  localparam int LEN_W = 13;

  logic                   i_clk = 1'b0;
  logic                   i_rst_n;
  logic [NCH-1:0]         i_ch_start, i_ch_abort;
  logic [NCH*XLEN-1:0]    i_ch_src, i_ch_dst;
  logic [NCH*LEN_W-1:0]   i_ch_len;
  logic [NCH-1:0]         o_ch_busy, o_ch_done;
  logic                   o_bus_req, i_bus_gnt, o_bus_read, o_bus_write;
  logic [XLEN-1:0]        o_bus_addr, o_bus_wr_data, i_bus_rd_data;
  logic [3:0]             o_bus_size;

  ids_dma_mc #(.XLEN(XLEN), .NUM_CH(NCH), .LEN_W(LEN_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_ch_start(i_ch_start), .i_ch_abort(i_ch_abort),
    .i_ch_src(i_ch_src), .i_ch_dst(i_ch_dst), .i_ch_len(i_ch_len),
    .o_ch_busy(o_ch_busy), .o_ch_done(o_ch_done),
    .o_bus_req(o_bus_req), .i_bus_gnt(i_bus_gnt), .o_bus_addr(o_bus_addr),
    .o_bus_read(o_bus_read), .o_bus_write(o_bus_write), .o_bus_size(o_bus_size),
    .o_bus_wr_data(o_bus_wr_data), .i_bus_rd_data(i_bus_rd_data)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  int m_last;
  bit gnt_rand = 1'b0;
  logic [31:0] j_src[NCH], j_dst[NCH];
  int          j_len[NCH];
  logic [31:0] exp_rd[$], exp_wa[$], exp_wd[$];
  int exp_done_cnt[NCH], exp_done_cyc[NCH], done_cnt[NCH], done_at[NCH];
  int busy_first[NCH], busy_last[NCH], busy_cnt[NCH];
  int viol, req_cnt;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  // Synchronous SRAM: data is only meaningful the cycle after a read strobe.
  always @(posedge i_clk)
    i_bus_rd_data <= o_bus_read ? mem_val(o_bus_addr) : 32'hDEAD_BEEF;

  always @(posedge i_clk) if (gnt_rand) begin
    #1;
    i_bus_gnt = ($urandom_range(0, 3) != 0);
  end

  always @(negedge i_clk) if (i_rst_n) begin
    if ((o_bus_read || o_bus_write) && !i_bus_gnt) viol++;
    if (o_bus_req) req_cnt++;
    if (o_bus_read) begin
      if (exp_rd.size() == 0) chk("rd_extra", 1, 0);
      else                    chk("rd_addr", o_bus_addr, exp_rd.pop_front());
    end
    if (o_bus_write) begin
      chk("wr_size", o_bus_size, 4'hF);
      if (exp_wa.size() == 0) chk("wr_extra", 1, 0);
      else begin
        chk("wr_addr", o_bus_addr, exp_wa.pop_front());
        chk("wr_data", o_bus_wr_data, exp_wd.pop_front());
      end
    end
    for (int k = 0; k < NCH; k++) begin
      if (o_ch_busy[k]) begin
        busy_cnt[k]++;
        if (busy_first[k] < 0) busy_first[k] = cyc;
        busy_last[k] = cyc;
      end
      if (o_ch_done[k]) begin
        done_cnt[k]++;
        done_at[k] = cyc;
        if (exp_done_cyc[k] >= 0) chk("done_cyc", cyc, exp_done_cyc[k]);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_mon();
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    viol = 0; req_cnt = 0;
    for (int k = 0; k < NCH; k++) begin
      exp_done_cnt[k] = 0; exp_done_cyc[k] = -1; done_cnt[k] = 0; done_at[k] = -1;
      busy_first[k] = -1; busy_last[k] = -1; busy_cnt[k] = 0;
    end
  endtask

  // Expected word stream: each service takes the next channel with words left after
  // the last one served; with a steady grant word j is written in cycle s+4(j+1).
  task automatic model_jobs(input logic [NCH-1:0] mask, input int s, input bit timed);
    int rem[NCH];
    int w[NCH];
    int j, k;
    logic [31:0] a;
    for (int c = 0; c < NCH; c++) begin
      rem[c] = mask[c] ? j_len[c] : 0;
      w[c] = 0;
      exp_done_cnt[c] = mask[c] ? 1 : 0;
      exp_done_cyc[c] = (mask[c] && (timed || j_len[c] == 0)) ? s + 1 : -1;
    end
    j = 0;
    while (rem.sum() > 0) begin
      k = -1;
      for (int d = NCH; d >= 1; d--)
        if (rem[(m_last + d) % NCH] > 0) k = (m_last + d) % NCH;
      a = j_src[k] + 32'(4 * w[k]);
      exp_rd.push_back(a);
      exp_wd.push_back(mem_val(a));
      exp_wa.push_back(j_dst[k] + 32'(4 * w[k]));
      w[k]++; rem[k]--; m_last = k;
      if (rem[k] == 0) exp_done_cyc[k] = timed ? s + 1 + 4 * (j + 1) : -1;
      j++;
    end
  endtask

  task automatic start_job(input logic [NCH-1:0] drv, input logic [NCH-1:0] mdl,
                           input bit timed, output int s);
    clear_mon();
    for (int k = 0; k < NCH; k++) begin
      i_ch_src[k*XLEN +: XLEN]   = j_src[k];
      i_ch_dst[k*XLEN +: XLEN]   = j_dst[k];
      i_ch_len[k*LEN_W +: LEN_W] = LEN_W'(j_len[k]);
    end
    s = cyc;
    model_jobs(mdl, s, timed);
    i_ch_start = drv;
    tick();
    i_ch_start = '0;
  endtask

  task automatic finish_test();
    int n = 0;
    while ((o_ch_busy != '0 || o_bus_req) && n < 2000) begin
      tick();
      n++;
    end
    chk("idle_timeout", (n < 2000), 1);
    repeat (4) tick();
    chk("rd_left", exp_rd.size(), 0);
    chk("wr_left", exp_wa.size(), 0);
    for (int k = 0; k < NCH; k++) chk("done_cnt", done_cnt[k], exp_done_cnt[k]);
    chk("strobe_no_gnt", viol, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, o_ch_busy, 0);
    chk({tag, "_done"}, o_ch_done, 0);
    chk({tag, "_req"}, o_bus_req, 0);
    chk({tag, "_addr"}, o_bus_addr, 0);
    chk({tag, "_read"}, o_bus_read, 0);
    chk({tag, "_write"}, o_bus_write, 0);
    chk({tag, "_size"}, o_bus_size, 0);
    chk({tag, "_wdata"}, o_bus_wr_data, 0);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    tick();
    clear_mon();
    m_last = NCH - 1;
    i_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s;
    logic [NCH-1:0] mask;
    bit rg;
    i_rst_n = 1'b0; i_ch_start = '0; i_ch_abort = '0;
    i_ch_src = '0; i_ch_dst = '0; i_ch_len = '0; i_bus_gnt = 1'b1;
    clear_mon();
    m_last = NCH - 1;
    repeat (3) tick();
    chk_zero("rst");
    i_rst_n = 1'b1;
    tick();

    // Single channel, four words, steady grant.
    j_src[0] = 32'h4000_1000; j_dst[0] = 32'h4000_0040; j_len[0] = 4;
    start_job(2'b01, 2'b01, 1'b1, s);
    finish_test();
    chk("t1_done_at", done_at[0], s + 17);
    chk("t1_busy_first", busy_first[0], s + 1);
    chk("t1_busy_last", busy_last[0], s + 16);
    chk("t1_busy_cnt", busy_cnt[0], 16);

    // Two channels from reset: ch0, ch1, ch0, ch0.
    do_reset();
    j_src[0] = 32'h2000_0000; j_dst[0] = 32'h3000_0000; j_len[0] = 3;
    j_src[1] = 32'h2000_0100; j_dst[1] = 32'h3000_0100; j_len[1] = 1;
    start_job(2'b11, 2'b11, 1'b1, s);
    finish_test();
    chk("t2_done_order", (done_at[1] < done_at[0]), 1);
    chk("t2_done1_at", done_at[1], s + 9);
    chk("t2_done0_at", done_at[0], s + 17);

    // Three stall cycles in RD of word 0, three more in its WR.
    j_src[0] = 32'h1234_5670; j_dst[0] = 32'h0000_8000; j_len[0] = 2;
    start_job(2'b01, 2'b01, 1'b1, s);
    exp_done_cyc[0] = s + 1 + 4 * 2 + 6;
    for (int off = 1; off <= 30; off++) begin
      i_bus_gnt = !((off >= 2 && off <= 4) || (off >= 7 && off <= 9));
      tick();
    end
    i_bus_gnt = 1'b1;
    finish_test();
    chk("t3_delay", done_at[0] - s, 15);

    // Zero-length start.
    j_len[0] = 0;
    start_job(2'b01, 2'b01, 1'b1, s);
    finish_test();
    chk("t4_done_at", done_at[0], s + 1);
    chk("t4_busy_cnt", busy_cnt[0], 0);
    chk("t4_req_cnt", req_cnt, 0);

    // Abort the winner during the WR of its second word.
    j_src[0] = 32'h0000_0100; j_dst[0] = 32'h0000_0900; j_len[0] = 4;
    start_job(2'b01, 2'b01, 1'b1, s);
    repeat (2) begin
      void'(exp_rd.pop_back()); void'(exp_wa.pop_back()); void'(exp_wd.pop_back());
    end
    exp_done_cnt[0] = 0; exp_done_cyc[0] = -1;
    while (cyc < s + 8) tick();
    chk("t5_busy_pre", o_ch_busy[0], 1);
    i_ch_abort = 2'b01;
    tick();
    i_ch_abort = '0;
    chk("t5_busy_post", o_ch_busy[0], 0);
    repeat (20) tick();
    finish_test();

    // Abort a non-winner: ch1 wins (ch0 was served last), ch0 is dropped at once.
    j_src[0] = 32'h0000_A000; j_dst[0] = 32'h0000_B000; j_len[0] = 3;
    j_src[1] = 32'h0000_C000; j_dst[1] = 32'h0000_D000; j_len[1] = 3;
    start_job(2'b11, 2'b10, 1'b1, s);
    tick();
    chk("t6_busy_pre", o_ch_busy[0], 1);
    i_ch_abort = 2'b01;
    tick();
    i_ch_abort = '0;
    chk("t6_busy_post", o_ch_busy[0], 0);
    finish_test();
    chk("t6_done1_at", done_at[1], s + 13);

    // Start and abort together: the channel never becomes busy.
    clear_mon();
    i_ch_len[0 +: LEN_W] = LEN_W'(3);
    i_ch_start = 2'b01; i_ch_abort = 2'b01;
    tick();
    i_ch_start = '0; i_ch_abort = '0;
    repeat (10) tick();
    chk("t7_busy", o_ch_busy, 0);
    finish_test();
    chk("t7_req_cnt", req_cnt, 0);

    // Address wrap, and a second start on the busy channel is ignored.
    j_src[0] = 32'hFFFF_FFFC; j_dst[0] = 32'h0000_0FF8; j_len[0] = 2;
    start_job(2'b01, 2'b01, 1'b1, s);
    repeat (2) tick();
    i_ch_src[0 +: XLEN] = 32'h5555_0000;
    i_ch_len[0 +: LEN_W] = LEN_W'(7);
    i_ch_start = 2'b01;
    tick();
    i_ch_start = '0;
    finish_test();

    // Reset mid-transfer forces all outputs low without a clock edge.
    j_src[0] = 32'h0000_4000; j_dst[0] = 32'h0000_6000; j_len[0] = 4;
    start_job(2'b01, 2'b01, 1'b1, s);
    while (cyc < s + 6) tick();
    chk("t9_req_pre", o_bus_req, 1);
    i_rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    tick();
    clear_mon();
    m_last = NCH - 1;
    i_rst_n = 1'b1;
    tick();

    for (int it = 0; it < 16; it++) begin
      mask = NCH'($urandom_range(1, 3));
      rg = 1'($urandom_range(0, 1));
      for (int k = 0; k < NCH; k++) begin
        j_len[k] = $urandom_range(0, 6);
        j_src[k] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
        j_dst[k] = $urandom & 32'hFFFF_FFFC;
      end
      gnt_rand = rg;
      start_job(mask, mask, !rg, s);
      finish_test();
      gnt_rand = 1'b0;
      tick();
      i_bus_gnt = 1'b1;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
